encoder_bus_arbiter: RTL and testbench

- Shares the single encoder register bus (addr/we/re/wdata/rdata) between two requesters: port 0 is the AXI4-Lite slave wrapper and port 1 is an on-chip sampler/DMA.
- Serialises accesses with one transaction in flight and round-robin arbitration.
- Decodes legal register offsets and returns read data with a completion pulse per port.
- Sits between the requesters and encoder_mmio.

---
 rtl/encoder_bus_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_encoder_bus_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_bus_arbiter.sv
// encoder_bus_arbiter: serialises two requesters onto the encoder register bus, one access in flight.
// Build option: define ENC_ARB_FIXED_PRIO_EN to make port 0 win every tie (default is round-robin).
module encoder_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              aclk,
    input  logic              aresetn,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              M0_GNT,
    output logic              M0_DONE,
    output logic [31:0]       M0_RDATA,
    output logic              M0_ERR,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              M1_GNT,
    output logic              M1_DONE,
    output logic [31:0]       M1_RDATA,
    output logic              M1_ERR,

    output logic [ADDR_W-1:0] BUS_ADDR,
    output logic              BUS_WE,
    output logic              BUS_RE,
    output logic [31:0]       BUS_WDATA,
    input  logic [31:0]       bus_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [1:0] CNT_LAST = 2'(RD_LAT - 1);

    state_t            state, state_d;
    logic              sel, sel_d;
    logic              we_l, we_l_d;
    logic              err_l, err_l_d;
    logic [1:0]        cnt, cnt_d;
`ifndef ENC_ARB_FIXED_PRIO_EN
    logic              last_gnt, last_gnt_d;
`endif

    logic              m0_gnt_d, m0_done_d, m0_err_d;
    logic              m1_gnt_d, m1_done_d, m1_err_d;
    logic [31:0]       m0_rdata_d, m1_rdata_d;
    logic [ADDR_W-1:0] bus_addr_d;
    logic [31:0]       bus_wdata_d;
    logic              bus_we_d, bus_re_d;

    logic              pick;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              req_err;

    function automatic logic decode_err(input logic we, input logic [7:0] off);
        if (we)
            return off != 8'h00;
        return !(off inside {8'h00, 8'h04, 8'h08, 8'h0C});
    endfunction

    always_comb begin : select
        pick = m1_req;
        if (m0_req && m1_req) begin
`ifdef ENC_ARB_FIXED_PRIO_EN
            pick = 1'b0;
`else
            pick = ~last_gnt;
`endif
        end
        req_we    = pick ? m1_we    : m0_we;
        req_addr  = pick ? m1_addr  : m0_addr;
        req_wdata = pick ? m1_wdata : m0_wdata;
        req_err   = decode_err(req_we, req_addr[7:0]);
    end

    // Decode is resolved on the grant edge so the ACCESS-cycle strobes come straight from flops.
    always_comb begin : next_state
        state_d     = state;
        sel_d       = sel;
        we_l_d      = we_l;
        err_l_d     = err_l;
        cnt_d       = cnt;
`ifndef ENC_ARB_FIXED_PRIO_EN
        last_gnt_d  = last_gnt;
`endif
        m0_gnt_d    = 1'b0;
        m1_gnt_d    = 1'b0;
        m0_done_d   = 1'b0;
        m1_done_d   = 1'b0;
        m0_err_d    = 1'b0;
        m1_err_d    = 1'b0;
        m0_rdata_d  = M0_RDATA;
        m1_rdata_d  = M1_RDATA;
        bus_addr_d  = BUS_ADDR;
        bus_wdata_d = BUS_WDATA;
        bus_we_d    = 1'b0;
        bus_re_d    = 1'b0;

        unique case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    sel_d       = pick;
                    we_l_d      = req_we;
                    err_l_d     = req_err;
`ifndef ENC_ARB_FIXED_PRIO_EN
                    last_gnt_d  = pick;
`endif
                    bus_addr_d  = req_addr;
                    bus_wdata_d = req_wdata;
                    m0_gnt_d    = ~pick;
                    m1_gnt_d    = pick;
                    bus_we_d    = req_we & ~req_err;
                    bus_re_d    = ~req_we & ~req_err;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (!we_l && !err_l) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    m0_done_d = ~sel;
                    m1_done_d = sel;
                    m0_err_d  = ~sel & err_l;
                    m1_err_d  = sel & err_l;
                    state_d   = RESP;
                end
            end
            WAIT: begin
                if (cnt == CNT_LAST) begin
                    m0_done_d = ~sel;
                    m1_done_d = sel;
                    if (sel)
                        m1_rdata_d = bus_rdata;
                    else
                        m0_rdata_d = bus_rdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt + 2'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            sel       <= 1'b0;
            we_l      <= 1'b0;
            err_l     <= 1'b0;
            cnt       <= '0;
`ifndef ENC_ARB_FIXED_PRIO_EN
            last_gnt  <= 1'b1;
`endif
            M0_GNT    <= 1'b0;
            M1_GNT    <= 1'b0;
            M0_DONE   <= 1'b0;
            M1_DONE   <= 1'b0;
            M0_ERR    <= 1'b0;
            M1_ERR    <= 1'b0;
            M0_RDATA  <= '0;
            M1_RDATA  <= '0;
            BUS_ADDR  <= '0;
            BUS_WDATA <= '0;
            BUS_WE    <= 1'b0;
            BUS_RE    <= 1'b0;
        end else begin
            state     <= state_d;
            sel       <= sel_d;
            we_l      <= we_l_d;
            err_l     <= err_l_d;
            cnt       <= cnt_d;
`ifndef ENC_ARB_FIXED_PRIO_EN
            last_gnt  <= last_gnt_d;
`endif
            M0_GNT    <= m0_gnt_d;
            M1_GNT    <= m1_gnt_d;
            M0_DONE   <= m0_done_d;
            M1_DONE   <= m1_done_d;
            M0_ERR    <= m0_err_d;
            M1_ERR    <= m1_err_d;
            M0_RDATA  <= m0_rdata_d;
            M1_RDATA  <= m1_rdata_d;
            BUS_ADDR  <= bus_addr_d;
            BUS_WDATA <= bus_wdata_d;
            BUS_WE    <= bus_we_d;
            BUS_RE    <= bus_re_d;
        end
    end

endmodule

// File: tb/tb_encoder_bus_arbiter.sv
// Bench for encoder_bus_arbiter: two instances (RD_LAT 1 and 3) driven alike, one observed at a time
// and compared cycle by cycle against a transaction-level timing model.
`timescale 1ns/1ps
module tb_encoder_bus_arbiter;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

`ifdef ENC_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, bus_rdata;

    logic [1:0]       a_gnt, a_done, a_err, b_gnt, b_done, b_err;
    logic [1:0][31:0] a_rdata, b_rdata;
    logic [31:0]      a_addr, a_wdata, b_addr, b_wdata;
    logic             a_we, a_re, b_we, b_re;

    logic [1:0]       o_gnt, o_done, o_err;
    logic [1:0][31:0] o_rdata;
    logic [31:0]      o_addr, o_wdata;
    logic             o_we, o_re;

    encoder_bus_arbiter #(.ADDR_W(32), .RD_LAT(1)) u_lat1 (
        .aclk(aclk), .aresetn(aresetn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .M0_GNT(a_gnt[0]), .M0_DONE(a_done[0]), .M0_RDATA(a_rdata[0]), .M0_ERR(a_err[0]),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .M1_GNT(a_gnt[1]), .M1_DONE(a_done[1]), .M1_RDATA(a_rdata[1]), .M1_ERR(a_err[1]),
        .BUS_ADDR(a_addr), .BUS_WE(a_we), .BUS_RE(a_re), .BUS_WDATA(a_wdata),
        .bus_rdata(bus_rdata)
    );

    encoder_bus_arbiter #(.ADDR_W(32), .RD_LAT(3)) u_lat3 (
        .aclk(aclk), .aresetn(aresetn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .M0_GNT(b_gnt[0]), .M0_DONE(b_done[0]), .M0_RDATA(b_rdata[0]), .M0_ERR(b_err[0]),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .M1_GNT(b_gnt[1]), .M1_DONE(b_done[1]), .M1_RDATA(b_rdata[1]), .M1_ERR(b_err[1]),
        .BUS_ADDR(b_addr), .BUS_WE(b_we), .BUS_RE(b_re), .BUS_WDATA(b_wdata),
        .bus_rdata(bus_rdata)
    );

    always #5 aclk = ~aclk;

    bit lat3 = 1'b0;
    int rdl  = 1;

    always_comb begin
        o_gnt   = lat3 ? b_gnt   : a_gnt;
        o_done  = lat3 ? b_done  : a_done;
        o_err   = lat3 ? b_err   : a_err;
        o_rdata = lat3 ? b_rdata : a_rdata;
        o_addr  = lat3 ? b_addr  : a_addr;
        o_wdata = lat3 ? b_wdata : a_wdata;
        o_we    = lat3 ? b_we    : a_we;
        o_re    = lat3 ? b_re    : a_re;
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Transaction model: one record with the cycle stamps at which each event must appear.
    int          t_port, t_gnt, t_done, last;
    bit          t_rd, t_wr, t_err;
    logic [31:0] t_addr, t_wdata;
    logic [31:0] exp_rdata [2];
    logic [31:0] exp_addr, exp_wdata;
    logic [31:0] hist [int];
    req_t        q [2][$];
    int          gnt_log [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic req_t rand_req();
        req_t        r;
        logic [31:0] hi;
        logic [31:0] lo_r;
        logic [7:0]  lo_tab [8];
        int unsigned idx;
        lo_tab  = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h01, 8'h00, 8'h0D};
        hi      = $urandom();
        lo_r    = $urandom();
        idx     = $urandom_range(0, 8);
        r.we    = 1'($urandom_range(0, 1));
        r.addr  = {hi[31:8], (idx == 8) ? lo_r[7:0] : lo_tab[idx]};
        r.wdata = $urandom();
        return r;
    endfunction

    function automatic req_t mk_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        req_t r;
        r.we    = we;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

    task automatic model_reset();
        t_gnt        = -100;
        t_done       = -100;
        t_port       = 0;
        t_rd         = 1'b0;
        t_wr         = 1'b0;
        t_err        = 1'b0;
        t_addr       = '0;
        t_wdata      = '0;
        last         = 1;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        exp_addr     = '0;
        exp_wdata    = '0;
        q[0].delete();
        q[1].delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, 64'({o_gnt, o_done, o_err, o_we, o_re}), 64'd0);
        check({tag, "_rdata"}, 64'(o_rdata), 64'd0);
        check({tag, "_bus"}, {o_addr, o_wdata}, 64'd0);
    endtask

    task automatic check_outputs();
        logic [1:0] e_gnt, e_done, e_err;
        e_gnt  = '0;
        e_done = '0;
        e_err  = '0;
        if (cyc == t_gnt) begin
            e_gnt[t_port] = 1'b1;
            exp_addr      = t_addr;
            exp_wdata     = t_wdata;
        end
        if (cyc == t_done) begin
            e_done[t_port] = 1'b1;
            e_err[t_port]  = t_err;
            if (t_rd)
                exp_rdata[t_port] = hist[t_gnt + rdl];
        end
        check("gnt", 64'(o_gnt), 64'(e_gnt));
        check("done", 64'(o_done), 64'(e_done));
        check("err", 64'(o_err), 64'(e_err));
        check("bus_re", 64'(o_re), 64'(cyc == t_gnt && t_rd));
        check("bus_we", 64'(o_we), 64'(cyc == t_gnt && t_wr));
        check("strobe_overlap", 64'(o_we & o_re), 64'd0);
        check("rdata0", 64'(o_rdata[0]), 64'(exp_rdata[0]));
        check("rdata1", 64'(o_rdata[1]), 64'(exp_rdata[1]));
        check("bus_addr_wdata", {o_addr, o_wdata}, {exp_addr, exp_wdata});
    endtask

    task automatic decide();
        bit   r0, r1;
        int   w;
        req_t r;
        r0 = q[0].size() > 0;
        r1 = q[1].size() > 0;
        if (cyc > t_done && (r0 || r1)) begin
            if (r0 && r1)
                w = FIXED ? 0 : 1 - last;
            else
                w = r1 ? 1 : 0;
            last    = w;
            r       = q[w][0];
            t_port  = w;
            t_gnt   = cyc + 1;
            t_rd    = !r.we && (r.addr[7:0] inside {8'h00, 8'h04, 8'h08, 8'h0C});
            t_wr    = r.we && r.addr[7:0] == 8'h00;
            t_err   = !(t_rd || t_wr);
            t_addr  = r.addr;
            t_wdata = r.wdata;
            t_done  = t_gnt + (t_rd ? rdl + 1 : 1);
        end
    endtask

    task automatic step();
        req_t r0, r1;
        @(posedge aclk);
        cyc++;
        #1;
        check_outputs();
        for (int p = 0; p < 2; p++) begin
            if (o_gnt[p]) begin
                gnt_log.push_back(p);
                if (q[p].size() > 0)
                    void'(q[p].pop_front());
            end
        end
        @(negedge aclk);
        bus_rdata = $urandom();
        hist[cyc] = bus_rdata;
        r0 = (q[0].size() > 0) ? q[0][0] : rand_req();
        r1 = (q[1].size() > 0) ? q[1][0] : rand_req();
        m0_req   = q[0].size() > 0;
        m0_we    = r0.we;
        m0_addr  = r0.addr;
        m0_wdata = r0.wdata;
        m1_req   = q[1].size() > 0;
        m1_we    = r1.we;
        m1_addr  = r1.addr;
        m1_wdata = r1.wdata;
        decide();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q[0].size() > 0 || q[1].size() > 0 || cyc <= t_done) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300)
            check("drain_timeout", 64'd1, 64'd0);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        m0_req  = 1'b0;
        m1_req  = 1'b0;
        model_reset();
        repeat (3) @(posedge aclk);
        #1;
        check_zero("reset");
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic random_phase(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            for (int p = 0; p < 2; p++)
                if (q[p].size() == 0 && $urandom_range(0, 2) == 0)
                    q[p].push_back(rand_req());
            step();
        end
        drain();
    endtask

    // Abort an in-flight read k cycles after its ACCESS cycle with an asynchronous reset.
    task automatic reset_mid(input int k);
        bit reached;
        reached = 1'b0;
        q[0].push_back(mk_req(1'b0, 32'hA5A5_000C, 32'h0));
        for (int i = 0; i < 30 && !reached; i++) begin
            step();
            if (cyc == t_gnt + k)
                reached = 1'b1;
        end
        check("mid_reached", 64'(reached), 64'd1);
        #2;
        aresetn = 1'b0;
        m0_req  = 1'b0;
        m1_req  = 1'b0;
        model_reset();
        #1;
        check_zero("async_reset");
        for (int i = 0; i < 4; i++) begin
            @(posedge aclk);
            #1;
            check("reset_no_done", 64'({o_done, o_gnt, o_re}), 64'd0);
        end
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    initial begin
        bus_rdata = '0;
        m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;

        // RD_LAT = 1 instance
        lat3 = 1'b0;
        rdl  = 1;
        do_reset();
        q[0].push_back(mk_req(1'b0, 32'h0000_0004, 32'h0));
        drain();
        q[1].push_back(mk_req(1'b1, 32'h0000_0000, 32'h0000_0005));
        drain();
        q[1].push_back(mk_req(1'b1, 32'h0000_0008, 32'h0000_0077));
        drain();
        q[0].push_back(mk_req(1'b0, 32'h0000_0010, 32'h0));
        drain();
        random_phase(500);

        // RD_LAT = 3 instance
        lat3 = 1'b1;
        rdl  = 3;
        do_reset();
        q[0].push_back(mk_req(1'b0, 32'h1234_560C, 32'h0));
        drain();
        random_phase(500);

        reset_mid(0);
        reset_mid(1);

        // Contention straight after reset: the first tie must go to port 0.
        gnt_log.delete();
        for (int i = 0; i < 4; i++) begin
            q[0].push_back(mk_req(1'b0, 32'h0000_0004, 32'h0));
            q[1].push_back(mk_req(1'b0, 32'h0000_0008, 32'h0));
        end
        drain();
        check("grant_count", 64'(gnt_log.size()), 64'd8);
        for (int i = 0; i < 4; i++)
            check("grant_order", 64'((i < gnt_log.size()) ? gnt_log[i] : 99),
                  64'(FIXED ? 0 : i % 2));

        q[1].push_back(mk_req(1'b1, 32'hFFFF_FF00, 32'hDEAD_BEEF));
        drain();

        lat3 = 1'b0;
        rdl  = 1;
        do_reset();
        random_phase(300);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
